fpu_result_seq: RTL and testbench

//  Issue/complete sequencer for the RV32F execute stage; sits directly upstream of the 9:1 FP result mux.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_busy_timer.sv | 40 ++++
 rtl/fpu_result_seq.sv | 160 ++++++++++++++++
 tb/tb_fpu_result_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the RV32F execute-stage result sequencer.
//   seq_state_t  : IDLE / BUSY / HOLD sequencer states (2-bit encoding)
//   SEL_NONE     : result-mux select when no valid unit result is presented
//   N_FP_UNITS   : number of result sources feeding the 9:1 result mux
//   FP_ADD..FP_CVT : unit indices (0..8), i.e. result-mux input numbers
// -----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    localparam logic [3:0] SEL_NONE   = 4'hF;
    localparam int         N_FP_UNITS = 9;

    // Units 0..4 complete in one cycle; 5..8 are the iterative ones.
    localparam logic [3:0] FP_ADD    = 4'd0;
    localparam logic [3:0] FP_MUL    = 4'd1;
    localparam logic [3:0] FP_SGNJ   = 4'd2;
    localparam logic [3:0] FP_MINMAX = 4'd3;
    localparam logic [3:0] FP_CMP    = 4'd4;
    localparam logic [3:0] FP_FMA    = 4'd5;
    localparam logic [3:0] FP_DIV    = 4'd6;
    localparam logic [3:0] FP_SQRT   = 4'd7;
    localparam logic [3:0] FP_CVT    = 4'd8;

endpackage

// File: rtl/fpu_busy_timer.sv
// -----------------------------------------------------------------------------
// fpu_busy_timer
// Saturating cycle counter used to bound how long the sequencer waits for a
// multi-cycle unit.
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : synchronous clear (has priority over i_en)
//   i_en     : count this cycle
//   o_hit    : this enabled cycle is the TIMEOUT_CYC-th one since the clear
// -----------------------------------------------------------------------------
module fpu_busy_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every always_ff reads the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CW'(TIMEOUT_CYC))) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Hit fires during the last allowed cycle, so the owner can leave on the
    // same edge at which the count would reach TIMEOUT_CYC.
    assign o_hit = i_en && (r_count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fpu_result_seq.sv
// -----------------------------------------------------------------------------
// fpu_result_seq
// Issue/complete sequencer in front of the 9:1 FP result mux. Accepts one op
// at a time, pulses the selected unit's start, waits for multi-cycle units,
// then presents the mux select with res_valid until writeback takes it.
//   clk, rst    : clock, asynchronous active-high reset
//   op_valid    : upstream presents an op          op_sel : target unit 0..8
//   op_ready    : can accept (IDLE only)           stall  : ~op_ready
//   flush       : kill any in-flight op, back to IDLE
//   unit_start  : one-hot single-cycle start pulse unit_done : unit completions
//   mux_sel     : result mux select, SEL_NONE when no unit result
//   res_valid   : result presented                  wb_ready : writeback takes it
//   illegal_op  : result is 0 because op_sel > 8
//   timeout     : result is 0 because the unit never completed
// -----------------------------------------------------------------------------
module fpu_result_seq
    import fpu_pkg::*;
#(
    parameter int                 N_UNITS     = N_FP_UNITS,
    parameter logic [N_UNITS-1:0] MULTI_MASK  = 9'h1E0,
    parameter int                 TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [3:0]         op_sel,
    output logic               op_ready,
    input  logic               flush,
    output logic [N_UNITS-1:0] unit_start,
    input  logic [N_UNITS-1:0] unit_done,
    output logic [3:0]         mux_sel,
    output logic               res_valid,
    input  logic               wb_ready,
    output logic               illegal_op,
    output logic               timeout,
    output logic               stall
);

    seq_state_t         r_state,      w_state_nxt;
    logic [3:0]         r_sel_q,      w_sel_nxt;
    logic [N_UNITS-1:0] r_unit_start, w_start_nxt;
    logic [3:0]         r_mux_sel,    w_mux_nxt;
    logic               r_res_valid,  w_valid_nxt;
    logic               r_illegal,    w_illegal_nxt;
    logic               r_timeout,    w_timeout_nxt;
    logic               w_timeout_hit;

    // Counter runs only while BUSY and is held at zero otherwise, so it reads
    // 0 in the first BUSY cycle.
    fpu_busy_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_busy_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state != BUSY),
        .i_en  (r_state == BUSY),
        .o_hit (w_timeout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sel_q      <= SEL_NONE;
            r_unit_start <= '0;
            r_mux_sel    <= SEL_NONE;
            r_res_valid  <= 1'b0;
            r_illegal    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel_q      <= w_sel_nxt;
            r_unit_start <= w_start_nxt;
            r_mux_sel    <= w_mux_nxt;
            r_res_valid  <= w_valid_nxt;
            r_illegal    <= w_illegal_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    // NOTE: every signal gets a default before any branch, so no path through
    // this block can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel_q;
        w_start_nxt   = '0;              // start is a pulse unless re-armed
        w_mux_nxt     = r_mux_sel;
        w_valid_nxt   = r_res_valid;
        w_illegal_nxt = r_illegal;
        w_timeout_nxt = r_timeout;

        if (flush) begin
            // Beats done, timeout, release and acceptance; no start pulse.
            w_state_nxt   = IDLE;
            w_mux_nxt     = SEL_NONE;
            w_valid_nxt   = 1'b0;
            w_illegal_nxt = 1'b0;
            w_timeout_nxt = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (op_valid) begin
                        w_sel_nxt = op_sel;
                        if (op_sel > 4'(N_UNITS - 1)) begin
                            w_state_nxt   = HOLD;
                            w_valid_nxt   = 1'b1;
                            w_illegal_nxt = 1'b1;
                        end else begin
                            w_start_nxt = N_UNITS'(1) << op_sel;
                            if (MULTI_MASK[op_sel]) begin
                                w_state_nxt = BUSY;
                            end else begin
                                w_state_nxt = HOLD;
                                w_mux_nxt   = op_sel;
                                w_valid_nxt = 1'b1;
                            end
                        end
                    end
                end
                BUSY: begin
                    // Completion of the owning unit wins over a coincident
                    // timeout; other units' done bits are not looked at.
                    if (unit_done[r_sel_q]) begin
                        w_state_nxt = HOLD;
                        w_mux_nxt   = r_sel_q;
                        w_valid_nxt = 1'b1;
                    end else if (w_timeout_hit) begin
                        w_state_nxt   = HOLD;
                        w_valid_nxt   = 1'b1;
                        w_timeout_nxt = 1'b1;
                    end
                end
                HOLD: begin
                    if (wb_ready) begin
                        w_state_nxt   = IDLE;
                        w_mux_nxt     = SEL_NONE;
                        w_valid_nxt   = 1'b0;
                        w_illegal_nxt = 1'b0;
                        w_timeout_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_mux_nxt     = SEL_NONE;
                    w_valid_nxt   = 1'b0;
                    w_illegal_nxt = 1'b0;
                    w_timeout_nxt = 1'b0;
                end
            endcase
        end
    end

    assign unit_start = r_unit_start;
    assign mux_sel    = r_mux_sel;
    assign res_valid  = r_res_valid;
    assign illegal_op = r_illegal;
    assign timeout    = r_timeout;
    assign op_ready   = (r_state == IDLE);
    assign stall      = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_result_seq.sv
// -----------------------------------------------------------------------------
// tb_fpu_result_seq
// Self-checking bench for fpu_result_seq: an op-level reference model tracks
// the single in-flight op and its age, a negedge process compares every
// output against it each cycle, and directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_fpu_result_seq;

    localparam int TIMEOUT_CYC = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [3:0] op_sel;
    logic       op_ready;
    logic       flush;
    logic [8:0] unit_start;
    logic [8:0] unit_done;
    logic [3:0] mux_sel;
    logic       res_valid;
    logic       wb_ready;
    logic       illegal_op;
    logic       timeout;
    logic       stall;

    int n_checks = 0;
    int n_errors = 0;

    fpu_result_seq #(
        .N_UNITS     (9),
        .MULTI_MASK  (9'h1E0),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_sel     (op_sel),
        .op_ready   (op_ready),
        .flush      (flush),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .mux_sel    (mux_sel),
        .res_valid  (res_valid),
        .wb_ready   (wb_ready),
        .illegal_op (illegal_op),
        .timeout    (timeout),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (op-level) ----------------
    // m_wait: a multi-cycle op is outstanding, m_age cycles old, on unit m_unit.
    bit         m_wait;
    int         m_age;
    int         m_unit;
    logic [8:0] e_start;
    logic [3:0] e_sel;
    bit         e_valid, e_ill, e_to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 0; m_age <= 0; m_unit <= 0;
            e_start <= '0; e_sel <= 4'hF; e_valid <= 0; e_ill <= 0; e_to <= 0;
        end else begin
            e_start <= '0;
            if (flush) begin
                m_wait <= 0; e_valid <= 0; e_ill <= 0; e_to <= 0; e_sel <= 4'hF;
            end else if (e_valid) begin
                if (wb_ready) begin
                    e_valid <= 0; e_ill <= 0; e_to <= 0; e_sel <= 4'hF;
                end
            end else if (m_wait) begin
                m_age <= m_age + 1;
                if (unit_done[m_unit]) begin
                    m_wait <= 0; e_valid <= 1; e_sel <= 4'(m_unit);
                end else if (m_age + 1 == TIMEOUT_CYC) begin
                    m_wait <= 0; e_valid <= 1; e_to <= 1;
                end
            end else if (op_valid) begin
                if (op_sel > 4'd8) begin
                    e_valid <= 1; e_ill <= 1;
                end else begin
                    e_start <= 9'(1) << op_sel;
                    if (op_sel >= 4'd5) begin
                        m_wait <= 1; m_age <= 0; m_unit <= int'(op_sel);
                    end else begin
                        e_valid <= 1; e_sel <= op_sel;
                    end
                end
            end
        end
    end

    // Per-cycle comparison, mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_unit_start", 32'(unit_start), 32'(e_start));
            check("cyc_mux_sel",    32'(mux_sel),    32'(e_sel));
            check("cyc_res_valid",  32'(res_valid),  32'(e_valid));
            check("cyc_illegal_op", 32'(illegal_op), 32'(e_ill));
            check("cyc_timeout",    32'(timeout),    32'(e_to));
            check("cyc_op_ready",   32'(op_ready),   32'(!m_wait && !e_valid));
            check("cyc_stall",      32'(stall),      32'(m_wait || e_valid));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] sel);
        op_valid = 1'b1;
        op_sel   = sel;
        tick();
        op_valid = 1'b0;
        op_sel   = 4'h0;
    endtask

    task automatic release_result();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 0; op_sel = 0; flush = 0; unit_done = '0; wb_ready = 0;
        repeat (2) tick();
        check("rst_mux_sel",  32'(mux_sel),  32'hF);
        check("rst_op_ready", 32'(op_ready), 32'h1);
        rst = 1'b0;
        tick();

        // Single-cycle unit 2: start pulse and result in the cycle after accept.
        wb_ready = 1'b1;
        issue(4'd2);
        check("sc_start",     32'(unit_start), 32'h004);
        check("sc_res_valid", 32'(res_valid),  32'h1);
        check("sc_mux_sel",   32'(mux_sel),    32'h2);
        check("sc_op_ready",  32'(op_ready),   32'h0);
        tick();
        wb_ready = 1'b0;
        check("sc_ready_back", 32'(op_ready),   32'h1);
        check("sc_start_gone", 32'(unit_start), 32'h000);
        check("sc_mux_none",   32'(mux_sel),    32'hF);

        // Multi-cycle unit 7, done in its 10th BUSY cycle, spurious done[5].
        issue(4'd7);
        check("mc_start", 32'(unit_start), 32'h080);
        for (int c = 1; c <= 9; c++) begin
            unit_done = (c == 3) ? 9'h020 : 9'h000;
            check("mc_busy_stall", 32'(stall), 32'h1);
            tick();
        end
        check("mc_no_early_valid", 32'(res_valid), 32'h0);
        unit_done = 9'h080;
        tick();
        unit_done = '0;
        for (int h = 0; h < 3; h++) begin
            check("mc_hold_valid", 32'(res_valid), 32'h1);
            check("mc_hold_sel",   32'(mux_sel),   32'h7);
            check("mc_hold_stall", 32'(stall),     32'h1);
            tick();
        end
        release_result();
        check("mc_released", 32'(op_ready), 32'h1);

        // Illegal op.
        issue(4'hC);
        check("ill_no_start", 32'(unit_start), 32'h000);
        check("ill_valid",    32'(res_valid),  32'h1);
        check("ill_flag",     32'(illegal_op), 32'h1);
        check("ill_mux",      32'(mux_sel),    32'hF);
        release_result();

        // Timeout on unit 8: BUSY cycles 1..64, result after the 64th.
        issue(4'd8);
        repeat (TIMEOUT_CYC - 1) tick();
        check("to_not_yet", 32'(res_valid), 32'h0);
        tick();
        check("to_valid", 32'(res_valid), 32'h1);
        check("to_flag",  32'(timeout),   32'h1);
        check("to_mux",   32'(mux_sel),   32'hF);
        release_result();

        // Done arriving in the timeout cycle wins.
        issue(4'd8);
        repeat (TIMEOUT_CYC - 1) tick();
        unit_done = 9'h100;
        tick();
        unit_done = '0;
        check("tie_valid",   32'(res_valid), 32'h1);
        check("tie_timeout", 32'(timeout),   32'h0);
        check("tie_mux",     32'(mux_sel),   32'h8);
        release_result();

        // Flush in BUSY with coincident done; later done in IDLE ignored.
        issue(4'd6);
        repeat (3) tick();
        flush = 1'b1; unit_done = 9'h040;
        tick();
        flush = 1'b0; unit_done = '0;
        check("fl_idle",     32'(op_ready),  32'h1);
        check("fl_no_valid", 32'(res_valid), 32'h0);
        check("fl_mux",      32'(mux_sel),   32'hF);
        unit_done = 9'h040;
        tick();
        unit_done = '0;
        check("fl_late_done", 32'(res_valid), 32'h0);

        // Flush coinciding with acceptance suppresses the start pulse.
        flush = 1'b1;
        issue(4'd1);
        flush = 1'b0;
        check("fl_acc_no_start", 32'(unit_start), 32'h000);
        check("fl_acc_idle",     32'(op_ready),   32'h1);

        // Flush in HOLD releases without wb_ready.
        issue(4'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_hold_idle", 32'(res_valid), 32'h0);

        // Asynchronous reset mid-BUSY: outputs clear without a clock edge.
        issue(4'd5);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_ready",  32'(op_ready),   32'h1);
        check("arst_mux",    32'(mux_sel),    32'hF);
        check("arst_valid",  32'(res_valid),  32'h0);
        check("arst_start",  32'(unit_start), 32'h000);
        check("arst_stall",  32'(stall),      32'h0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
